// File: rtl/in12_scan_driver.sv
// IN-12 nixie row driver with a shared keyboard matrix scan.
// Sequencer strobes act on their rising edge; new key presses land in a one-entry valid/ack register.
module in12_scan_driver #(
  parameter int DIGITS = 8,
  parameter int ROWS   = 4
) (
  input  logic                                   Clock_1us,
  input  logic                                   Rst,
  input  logic                                   digit_wr,
  input  logic [$clog2(DIGITS)-1:0]              digit_addr,
  input  logic [3:0]                             digit_data,
  input  logic                                   in12_write_cathode,
  input  logic                                   in12_write_anode,
  input  logic                                   keyboard_write,
  input  logic                                   keyboard_read,
  input  logic [ROWS-1:0]                        kb_rows,
  output logic [9:0]                             cathode,
  output logic [DIGITS-1:0]                      anode,
  output logic [$clog2(DIGITS)-1:0]              kb_col,
  output logic                                   key_valid,
  output logic [$clog2(DIGITS)+$clog2(ROWS)-1:0] key_code,
  input  logic                                   key_ack,
  output logic                                   key_overflow,
  output logic                                   frame_done
);
  localparam int AW = $clog2(DIGITS);
  localparam int RW = $clog2(ROWS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DIGITS - 1);

  logic              cath_s_q, anode_s_q, kbw_s_q, kbr_s_q;
  logic              cath_rise, anode_rise, kbw_rise, kbr_rise;
  logic [AW-1:0]     anode_idx_q, anode_idx_d, next_idx;
  logic [AW-1:0]     col_q, col_d;
  logic [3:0]        digit_buf_q [DIGITS];
  logic [3:0]        digit_buf_d [DIGITS];
  logic [ROWS-1:0]   prev_q [DIGITS];
  logic [ROWS-1:0]   prev_d [DIGITS];
  logic [9:0]        cathode_q, cathode_d, dec;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic              frame_done_q, frame_done_d;
  logic              key_valid_q, key_valid_d;
  logic              key_overflow_q, key_overflow_d;
  logic [AW+RW-1:0]  key_code_q, key_code_d;
  logic              wr_ok;
  logic [3:0]        sel_digit;
  logic [ROWS-1:0]   press;
  logic [RW-1:0]     first_row;
  int                n_press;

  assign cath_rise  = in12_write_cathode & ~cath_s_q;
  assign anode_rise = in12_write_anode   & ~anode_s_q;
  assign kbw_rise   = keyboard_write     & ~kbw_s_q;
  assign kbr_rise   = keyboard_read      & ~kbr_s_q;

  assign wr_ok     = digit_wr && (int'(digit_addr) < DIGITS);
  assign next_idx  = (anode_idx_q == LAST_IDX) ? '0 : anode_idx_q + 1'b1;
  // A write landing on the digit being selected is forwarded straight to the cathodes.
  assign sel_digit = (wr_ok && digit_addr == next_idx) ? digit_data : digit_buf_q[next_idx];

  for (genvar gi = 0; gi < 10; gi++) begin : g_dec
    assign dec[gi] = (sel_digit == 4'(gi));
  end

  always_comb begin
    digit_buf_d = digit_buf_q;
    if (wr_ok) digit_buf_d[digit_addr] = digit_data;

    anode_idx_d  = cath_rise ? next_idx : anode_idx_q;
    cathode_d    = cathode_q;
    anode_d      = anode_q;
    frame_done_d = 1'b0;
    if (cath_rise) begin
      cathode_d = dec;
      anode_d   = '0;
    end
    // Anode uses the post-cathode index so a coincident pair still lines up.
    if (anode_rise) begin
      anode_d              = '0;
      anode_d[anode_idx_d] = 1'b1;
      frame_done_d         = (anode_idx_d == LAST_IDX);
    end
  end

  always_comb begin
    col_d  = kbw_rise ? anode_idx_q : col_q;
    prev_d = prev_q;
    press  = '0;
    if (kbr_rise) begin
      press          = kb_rows & ~prev_q[col_q];
      prev_d[col_q]  = kb_rows;
    end

    first_row = '0;
    n_press   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (press[r]) begin
        first_row = RW'(r);
        n_press   = n_press + 1;
      end
    end

    key_valid_d    = key_valid_q;
    key_code_d     = key_code_q;
    key_overflow_d = key_overflow_q;
    if (press != '0) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = {col_q, first_row};
        key_valid_d = 1'b1;
      end else begin
        key_overflow_d = 1'b1;
      end
      if (n_press > 1) key_overflow_d = 1'b1;
    end else if (key_ack) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock_1us) begin
    if (Rst) begin
      cath_s_q       <= 1'b0;
      anode_s_q      <= 1'b0;
      kbw_s_q        <= 1'b0;
      kbr_s_q        <= 1'b0;
      anode_idx_q    <= LAST_IDX;
      col_q          <= LAST_IDX;
      cathode_q      <= '0;
      anode_q        <= '0;
      frame_done_q   <= 1'b0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_overflow_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        digit_buf_q[i] <= 4'hF;
        prev_q[i]      <= '0;
      end
    end else begin
      cath_s_q       <= in12_write_cathode;
      anode_s_q      <= in12_write_anode;
      kbw_s_q        <= keyboard_write;
      kbr_s_q        <= keyboard_read;
      anode_idx_q    <= anode_idx_d;
      col_q          <= col_d;
      cathode_q      <= cathode_d;
      anode_q        <= anode_d;
      frame_done_q   <= frame_done_d;
      key_valid_q    <= key_valid_d;
      key_code_q     <= key_code_d;
      key_overflow_q <= key_overflow_d;
      digit_buf_q    <= digit_buf_d;
      prev_q         <= prev_d;
    end
  end

  assign cathode      = cathode_q;
  assign anode        = anode_q;
  assign kb_col       = anode_idx_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_overflow = key_overflow_q;
  assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_in12_scan_driver.sv
// Bench for in12_scan_driver: directed scenarios plus random strobes checked every cycle
// against an integer-arithmetic reference model.
module tb_in12_scan_driver;
  localparam int DIGITS = 8;
  localparam int ROWS   = 4;

  logic       Clock_1us = 1'b0;
  logic       Rst;
  logic       digit_wr;
  logic [2:0] digit_addr;
  logic [3:0] digit_data;
  logic       in12_write_cathode, in12_write_anode, keyboard_write, keyboard_read;
  logic [3:0] kb_rows;
  logic [9:0] cathode;
  logic [7:0] anode;
  logic [2:0] kb_col;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ack;
  logic       key_overflow;
  logic       frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  in12_scan_driver #(.DIGITS(DIGITS), .ROWS(ROWS)) dut (
    .Clock_1us(Clock_1us), .Rst(Rst), .digit_wr(digit_wr), .digit_addr(digit_addr),
    .digit_data(digit_data), .in12_write_cathode(in12_write_cathode),
    .in12_write_anode(in12_write_anode), .keyboard_write(keyboard_write),
    .keyboard_read(keyboard_read), .kb_rows(kb_rows), .cathode(cathode), .anode(anode),
    .kb_col(kb_col), .key_valid(key_valid), .key_code(key_code), .key_ack(key_ack),
    .key_overflow(key_overflow), .frame_done(frame_done)
  );

  always #5 Clock_1us = ~Clock_1us;

  // Reference model state, plain integers.
  int m_idx, m_col, m_cath, m_anode, m_code;
  int m_buf  [DIGITS];
  int m_prev [DIGITS];
  bit m_cs, m_as, m_ws, m_rs, m_valid, m_ovf, m_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit cr, ar, wr, rr;
    int d, newp, r, old_idx;
    if (Rst) begin
      m_idx = DIGITS - 1; m_col = DIGITS - 1;
      m_cath = 0; m_anode = 0; m_code = 0;
      m_valid = 0; m_ovf = 0; m_fd = 0;
      m_cs = 0; m_as = 0; m_ws = 0; m_rs = 0;
      for (int i = 0; i < DIGITS; i++) begin m_buf[i] = 15; m_prev[i] = 0; end
      return;
    end
    cr = in12_write_cathode && !m_cs;
    ar = in12_write_anode && !m_as;
    wr = keyboard_write && !m_ws;
    rr = keyboard_read && !m_rs;
    m_cs = in12_write_cathode; m_as = in12_write_anode;
    m_ws = keyboard_write;     m_rs = keyboard_read;
    old_idx = m_idx;
    m_fd = 0;
    if (cr) begin
      m_idx = (m_idx + 1) % DIGITS;
      d = (digit_wr && int'(digit_addr) == m_idx) ? int'(digit_data) : m_buf[m_idx];
      m_cath  = (d < 10) ? (1 << d) : 0;
      m_anode = 0;
    end
    if (ar) begin
      m_anode = 1 << m_idx;
      m_fd    = (m_idx == DIGITS - 1);
    end
    if (digit_wr) m_buf[digit_addr] = int'(digit_data);
    newp = 0;
    if (rr) begin
      newp = int'(kb_rows) & ~m_prev[m_col] & ((1 << ROWS) - 1);
      m_prev[m_col] = int'(kb_rows);
    end
    if (newp != 0) begin
      r = 0;
      while (((newp >> r) & 1) == 0) r++;
      if (!m_valid || key_ack) begin
        m_code  = m_col * ROWS + r;
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
      if ($countones(newp) > 1) m_ovf = 1;
    end else if (key_ack) begin
      m_valid = 0;
    end
    if (wr) m_col = old_idx;
  endfunction

  task automatic check_all();
    check("cathode", 32'(cathode), 32'(m_cath));
    check("anode", 32'(anode), 32'(m_anode));
    check("kb_col", 32'(kb_col), 32'(m_idx));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_overflow", 32'(key_overflow), 32'(m_ovf));
    check("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock_1us);
    #1;
    check_all();
    @(negedge Clock_1us);
  endtask

  task automatic do_reset();
    Rst = 1'b1; tick(); Rst = 1'b0;
    $display("[TB] reset");
  endtask

  task automatic write_digit(input int a, input int v);
    digit_wr = 1'b1; digit_addr = 3'(a); digit_data = 4'(v);
    tick();
    digit_wr = 1'b0;
    $display("[TB] write buf[%0d]=%0d", a, v);
  endtask

  task automatic cath_pulse();
    in12_write_cathode = 1'b1; tick();
    in12_write_cathode = 1'b0; tick();
    $display("[TB] cathode pulse -> idx %0d cathode %b", kb_col, cathode);
  endtask

  task automatic anode_pulse(output bit fd);
    in12_write_anode = 1'b1; tick();
    fd = frame_done;
    in12_write_anode = 1'b0; tick();
    $display("[TB] anode pulse -> anode %b frame_done %0b", anode, fd);
  endtask

  task automatic kb_write();
    keyboard_write = 1'b1; tick();
    keyboard_write = 1'b0; tick();
    $display("[TB] kb column latch %0d", kb_col);
  endtask

  task automatic kb_read(input logic [3:0] rows, input bit ack);
    kb_rows = rows; keyboard_read = 1'b1; key_ack = ack; tick();
    keyboard_read = 1'b0; key_ack = 1'b0; tick();
    $display("[TB] kb read rows %b ack %0b -> valid %0b code %0d ovf %0b",
             rows, ack, key_valid, key_code, key_overflow);
  endtask

  initial begin
    bit fd;
    Rst = 1'b1; digit_wr = 1'b0; digit_addr = '0; digit_data = '0;
    in12_write_cathode = 1'b0; in12_write_anode = 1'b0;
    keyboard_write = 1'b0; keyboard_read = 1'b0; kb_rows = '0; key_ack = 1'b0;

    // Reset state and first digit.
    do_reset();
    check("rst_kb_col", 32'(kb_col), 32'd7);
    check("rst_cathode", 32'(cathode), 32'd0);
    write_digit(0, 3);
    cath_pulse();
    anode_pulse(fd);
    check("t1_cathode", 32'(cathode), 32'b0000001000);
    check("t1_anode", 32'(anode), 32'b00000001);
    check("t1_kb_col", 32'(kb_col), 32'd0);

    // Full frame with digits 0..7.
    do_reset();
    for (int i = 0; i < DIGITS; i++) write_digit(i, i);
    for (int i = 0; i < DIGITS; i++) begin
      cath_pulse();
      anode_pulse(fd);
      check("frame_cathode", 32'(cathode), 32'(1 << i));
      check("frame_done_pulse", 32'(fd), 32'(i == DIGITS - 1));
    end
    cath_pulse();
    anode_pulse(fd);
    check("wrap_anode", 32'(anode), 32'b00000001);

    // Cathode strobe held three cycles advances once and blanks the anode.
    in12_write_cathode = 1'b1;
    tick(); tick(); tick();
    check("hold_kb_col", 32'(kb_col), 32'd1);
    check("hold_anode", 32'(anode), 32'd0);
    in12_write_cathode = 1'b0; tick();
    anode_pulse(fd);
    check("hold_anode_after", 32'(anode), 32'b00000010);

    // Two rows on column 2: lowest reported, extra sets overflow.
    cath_pulse();
    kb_write();
    kb_read(4'b0110, 1'b0);
    check("kb2_valid", 32'(key_valid), 32'd1);
    check("kb2_code", 32'(key_code), 32'd9);
    check("kb2_ovf", 32'(key_overflow), 32'd1);
    kb_read(4'b0110, 1'b1);
    check("kb2_no_repeat", 32'(key_valid), 32'd0);

    // Ack coincident with a new press versus a press with no ack.
    do_reset();
    kb_write();
    kb_read(4'b1000, 1'b0);
    check("kb7_code", 32'(key_code), 32'd31);
    for (int i = 0; i < 6; i++) cath_pulse();
    kb_write();
    kb_read(4'b0001, 1'b1);
    check("kb5_code", 32'(key_code), 32'd20);
    check("kb5_valid", 32'(key_valid), 32'd1);
    check("kb5_ovf", 32'(key_overflow), 32'd0);
    kb_read(4'b0101, 1'b0);
    check("kb5b_ovf", 32'(key_overflow), 32'd1);
    check("kb5b_code", 32'(key_code), 32'd20);

    // Write bypass on the selected digit, then reset mid-frame.
    do_reset();
    write_digit(1, 4);
    cath_pulse();
    digit_wr = 1'b1; digit_addr = 3'd1; digit_data = 4'd12; in12_write_cathode = 1'b1;
    tick();
    digit_wr = 1'b0; in12_write_cathode = 1'b0;
    tick();
    check("bypass_blank", 32'(cathode), 32'd0);
    anode_pulse(fd);
    Rst = 1'b1; tick(); Rst = 1'b0;
    check("midrst_anode", 32'(anode), 32'd0);
    check("midrst_kb_col", 32'(kb_col), 32'd7);

    // Randomised traffic, checked every cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      Rst                = ($urandom_range(0, 299) == 0);
      in12_write_cathode = ($urandom_range(0, 2) == 0);
      in12_write_anode   = ($urandom_range(0, 2) == 0);
      keyboard_write     = ($urandom_range(0, 2) == 0);
      keyboard_read      = ($urandom_range(0, 2) == 0);
      key_ack            = ($urandom_range(0, 3) == 0);
      digit_wr           = ($urandom_range(0, 3) == 0);
      digit_addr         = 3'($urandom_range(0, 7));
      digit_data         = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) kb_rows = 4'($urandom_range(0, 15));
      tick();
    end
    $display("[TB] random phase complete");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
